booth_mul_seq: RTL

Handshake sequencer wrapped around the serial Booth multiplier (`BoothAlgorithm_n`, n+1-bit signed operands, 2n+2-bit product). It accepts operand pairs on a valid/ready input channel and holds them stable. It starts the multiplier by holding it in reset, then releasing it, and waits for the multiplier's done flag. It captures the product and presents it on a valid/ready output channel. It also detects a hung multiplier with a timeout and counts completed operations.

---
 rtl/booth_mul_seq_if.sv | 24 ++
 rtl/booth_mul_seq.sv | 117 +++++++++++
 2 files changed

// File: rtl/booth_mul_seq_if.sv
// Host-side channels of the Booth multiplier sequencer: operand input and result output,
// each with its own valid/ready handshake.
interface booth_mul_seq_if #(
  parameter int n = 8
);
  logic           in_valid_i;
  logic           in_ready_o;
  logic [n:0]     a_i;
  logic [n:0]     b_i;
  logic           out_valid_o;
  logic           out_ready_i;
  logic [2*n+1:0] y_o;
  logic           err_o;

  modport master (
    output in_valid_i, a_i, b_i, out_ready_i,
    input  in_ready_o, out_valid_o, y_o, err_o
  );

  modport slave (
    input  in_valid_i, a_i, b_i, out_ready_i,
    output in_ready_o, out_valid_o, y_o, err_o
  );
endinterface

// File: rtl/booth_mul_seq.sv
// Handshake sequencer around the serial Booth multiplier: loads operands by pulsing the
// multiplier through reset, waits for its done flag (or a timeout) and hands off the product.
module booth_mul_seq #(
  parameter int n   = 8,
  parameter int TMO = 20
) (
  input  logic           clk_i,
  input  logic           rst_i,
  booth_mul_seq_if.slave host,
  output logic           busy_o,
  output logic [15:0]    ops_o,
  output logic [n:0]     mul_a_o,
  output logic [n:0]     mul_b_o,
  output logic           mul_rst_o,
  input  logic           mul_fl_i,
  input  logic [2*n+1:0] mul_y_i
);
  localparam int TW = $clog2(TMO + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] BUSY = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [n:0]     a_q, a_d;
  logic [n:0]     b_q, b_d;
  logic [2*n+1:0] y_q, y_d;
  logic           err_q, err_d;
  logic [15:0]    ops_q, ops_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           in_xfer;
  logic           out_xfer;

  // In DONE a new pair may only enter in the same cycle the current result leaves.
  assign host.in_ready_o = (state_q == IDLE) || ((state_q == DONE) && host.out_ready_i);
  assign in_xfer         = host.in_valid_i && host.in_ready_o;
  assign out_xfer        = (state_q == DONE) && host.out_ready_i;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    err_d   = err_q;
    ops_d   = ops_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        if (in_xfer) begin
          a_d     = host.a_i;
          b_d     = host.b_i;
          state_d = LOAD;
        end
      end
      LOAD: begin
        tmo_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        tmo_d = tmo_q + TW'(1);
        if (mul_fl_i) begin
          y_d     = mul_y_i;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (tmo_q == TW'(TMO - 1)) begin
          y_d     = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_xfer) begin
          ops_d = ops_q + 16'd1;
          if (in_xfer) begin
            a_d     = host.a_i;
            b_d     = host.b_i;
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
      ops_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      err_q   <= err_d;
      ops_q   <= ops_d;
      tmo_q   <= tmo_d;
    end
  end

  // The multiplier runs only in BUSY; every other state parks it in reset.
  assign host.out_valid_o = (state_q == DONE);
  assign host.y_o         = y_q;
  assign host.err_o       = err_q;
  assign busy_o           = (state_q == LOAD) || (state_q == BUSY);
  assign ops_o            = ops_q;
  assign mul_a_o          = a_q;
  assign mul_b_o          = b_q;
  assign mul_rst_o        = (state_q != BUSY);
endmodule
